// File: rtl/bldc_pwm_driver.sv
// ---------------------------------------------------------------------------
// bldc_pwm_driver
//
// Six-step BLDC gate driver. It contains:
//   - a PWM generator with shadowed PERIOD/DUTY registers
//   - Hall-driven commutation (forward or reverse) and a brake pattern
//   - a dead-time FSM between gate pattern changes
//   - a latched over-current fault
//   - Hall edge-to-edge period measurement
// The block is an 8-bit Avalon-MM register slave.
//
// Ports
//   csi_MCLK_clk        single clock for bus, PWM and gate logic
//   rsi_MRST_reset_n    asynchronous active-low reset
//   avs_ctrl_address    register address (0..9 decoded)
//   avs_ctrl_write      write strobe
//   avs_ctrl_read       read strobe
//   avs_ctrl_writedata  write data
//   avs_ctrl_readdata   registered read data, valid one cycle after read
//   I_limit             asynchronous over-current input, active high
//   Ha, Hb, Hc          asynchronous Hall sensor inputs
//   Lau, Lbu, Lcu       high-side gates (PWM chopped)
//   Lad, Lbd, Lcd       low-side gates (never chopped)
//
// Register map
//   0 CTRL         bit0 enable, bit1 forward, bit2 brake, bit3 fault_clear
//   1 STATUS       bit0 fault, bit1 hall_err, bit2 running, bits6:4 {Ha,Hb,Hc}
//   2/3 PERIOD     low/high byte
//   4/5 DUTY       low/high byte
//   6 DEADTIME
//   7/8/9          HALL_PERIOD bytes 0/1/2 (reading 7 snapshots bytes 1/2)
// ---------------------------------------------------------------------------
module bldc_pwm_driver #(
  parameter int PWM_WIDTH = 16,
  parameter int DT_WIDTH  = 8,
  parameter int HP_WIDTH  = 24
) (
  input  logic       csi_MCLK_clk,
  input  logic       rsi_MRST_reset_n,
  input  logic [3:0] avs_ctrl_address,
  input  logic       avs_ctrl_write,
  input  logic       avs_ctrl_read,
  input  logic [7:0] avs_ctrl_writedata,
  output logic [7:0] avs_ctrl_readdata,
  input  logic       I_limit,
  input  logic       Ha,
  input  logic       Hb,
  input  logic       Hc,
  output logic       Lau,
  output logic       Lbu,
  output logic       Lcu,
  output logic       Lad,
  output logic       Lbd,
  output logic       Lcd
);

  localparam logic [23:0] HP_ONES24 = 24'({HP_WIDTH{1'b1}});

  typedef enum logic {ST_RUN, ST_DEAD} dt_state_t;

  // Commutation table, Hall order {Ha,Hb,Hc}; result {Lau,Lbu,Lcu,Lad,Lbd,Lcd}
  function automatic logic [5:0] f_commutate(input logic [2:0] hall, input logic fwd);
    logic [5:0] pat;
    pat = 6'b000000;
    case (hall)
      3'b100: pat = fwd ? 6'b100001 : 6'b001100;
      3'b110: pat = fwd ? 6'b010001 : 6'b001010;
      3'b010: pat = fwd ? 6'b010100 : 6'b100010;
      3'b011: pat = fwd ? 6'b001100 : 6'b100001;
      3'b001: pat = fwd ? 6'b001010 : 6'b010001;
      3'b101: pat = fwd ? 6'b100010 : 6'b010100;
      default: pat = 6'b000000;
    endcase
    return pat;
  endfunction

  // Only the high sides are chopped; the brake pattern has no high sides set
  function automatic logic [5:0] f_gate(input logic [5:0] pat, input logic on);
    return {pat[5:3] & {3{on}}, pat[2:0]};
  endfunction

  // Synchronisers
  logic                 r_ilim_s1, r_ilim_s2;
  logic [2:0]           r_hall_s1, r_hall_s2;

  // Registers
  logic [2:0]           r_ctrl;
  logic [PWM_WIDTH-1:0] r_per_sh, r_duty_sh, r_per, r_duty, r_cnt;
  logic [DT_WIDTH-1:0]  r_dt, r_dt_cnt;
  logic                 r_fault, r_hall_err;
  logic [2:0]           r_hall_last;
  logic [HP_WIDTH-1:0]  r_hp_cnt, r_hp;
  logic [15:0]          r_hp_snap_hi;
  dt_state_t            r_state;
  logic [5:0]           r_applied, r_gate;

  logic                 w_fclr, w_fault_now, w_pwm_on, w_hall_bad, w_hall_chg;
  logic                 w_running;
  logic [5:0]           w_desired;
  logic [15:0]          w_per16, w_duty16;
  logic [23:0]          w_hp24;
  logic [7:0]           w_rd_mux;

  assign {Lau, Lbu, Lcu, Lad, Lbd, Lcd} = r_gate;

  assign w_fclr      = avs_ctrl_write && (avs_ctrl_address == 4'd0) && avs_ctrl_writedata[3];
  assign w_fault_now = r_fault | r_ilim_s2;
  assign w_pwm_on    = (r_per != '0) && (r_cnt < r_duty);
  assign w_hall_chg  = (r_hall_s2 != 3'b000) && (r_hall_s2 != 3'b111) &&
                       (r_hall_s2 != r_hall_last);
  assign w_running   = r_ctrl[0] && (r_hp != '1);
  assign w_per16     = 16'(r_per_sh);
  assign w_duty16    = 16'(r_duty_sh);
  assign w_hp24      = 24'(r_hp);

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_ilim_s1 <= 1'b0;
      r_ilim_s2 <= 1'b0;
      r_hall_s1 <= 3'b000;
      r_hall_s2 <= 3'b000;
    end else begin
      r_ilim_s1 <= I_limit;
      r_ilim_s2 <= r_ilim_s1;
      r_hall_s1 <= {Ha, Hb, Hc};
      r_hall_s2 <= r_hall_s1;
    end
  end

  // Bus register writes; PERIOD/DUTY land in shadow copies
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_ctrl    <= 3'b000;
      r_per_sh  <= '0;
      r_duty_sh <= '0;
      r_dt      <= '0;
    end else if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        4'd0: r_ctrl                      <= avs_ctrl_writedata[2:0];
        4'd2: r_per_sh[7:0]               <= avs_ctrl_writedata;
        4'd3: r_per_sh[PWM_WIDTH-1:8]     <= avs_ctrl_writedata[PWM_WIDTH-9:0];
        4'd4: r_duty_sh[7:0]              <= avs_ctrl_writedata;
        4'd5: r_duty_sh[PWM_WIDTH-1:8]    <= avs_ctrl_writedata[PWM_WIDTH-9:0];
        4'd6: r_dt                        <= avs_ctrl_writedata[DT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // PWM counter; shadows become active only at the wrap
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_cnt  <= '0;
      r_per  <= '0;
      r_duty <= '0;
    end else if (r_cnt >= r_per) begin
      r_cnt  <= '0;
      r_per  <= r_per_sh;
      r_duty <= r_duty_sh;
    end else begin
      r_cnt  <= r_cnt + PWM_WIDTH'(1);
    end
  end

  // Desired pattern in priority order; hall_err is raised only when the
  // Hall state is actually used to commutate
  always_comb begin
    w_desired  = 6'b000000;
    w_hall_bad = 1'b0;
    if (w_fault_now || !r_ctrl[0]) begin
      w_desired = 6'b000000;
    end else if (r_ctrl[2]) begin
      w_desired = 6'b000111;
    end else if (r_hall_s2 == 3'b000 || r_hall_s2 == 3'b111) begin
      w_hall_bad = 1'b1;
    end else begin
      w_desired = f_commutate(r_hall_s2, r_ctrl[1]);
    end
  end

  // Set dominates clear so a clear during an active condition is ignored
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_fault    <= 1'b0;
      r_hall_err <= 1'b0;
    end else begin
      if (r_ilim_s2)    r_fault <= 1'b1;
      else if (w_fclr)  r_fault <= 1'b0;
      if (w_hall_bad)   r_hall_err <= 1'b1;
      else if (w_fclr)  r_hall_err <= 1'b0;
    end
  end

  // Dead-time FSM; gates are registered alongside the applied pattern so the
  // new pattern reaches the pins on the same edge it is applied
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_state   <= ST_RUN;
      r_applied <= 6'b000000;
      r_dt_cnt  <= '0;
      r_gate    <= 6'b000000;
    end else if (w_fault_now) begin
      r_state   <= ST_RUN;
      r_applied <= 6'b000000;
      r_dt_cnt  <= '0;
      r_gate    <= 6'b000000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_desired != r_applied) begin
            if (r_dt != '0) begin
              r_state   <= ST_DEAD;
              r_applied <= 6'b000000;
              r_dt_cnt  <= r_dt;
              r_gate    <= 6'b000000;
            end else begin
              r_applied <= w_desired;
              r_gate    <= f_gate(w_desired, w_pwm_on);
            end
          end else begin
            r_gate <= f_gate(r_applied, w_pwm_on);
          end
        end
        ST_DEAD: begin
          // Counter reaching 0 on this edge ends the dead time; desired
          // changes meanwhile are picked up here without restarting it
          if (r_dt_cnt <= DT_WIDTH'(1)) begin
            r_state   <= ST_RUN;
            r_dt_cnt  <= '0;
            r_applied <= w_desired;
            r_gate    <= f_gate(w_desired, w_pwm_on);
          end else begin
            r_dt_cnt  <= r_dt_cnt - DT_WIDTH'(1);
            r_gate    <= 6'b000000;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_applied <= 6'b000000;
          r_gate    <= 6'b000000;
        end
      endcase
    end
  end

  // Hall period: counter restarts at 1 on each valid edge, so the captured
  // value is the edge-to-edge cycle count; saturation reports all-ones
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_hall_last <= 3'b000;
      r_hp_cnt    <= '1;
      r_hp        <= '1;
    end else if (w_hall_chg) begin
      r_hall_last <= r_hall_s2;
      r_hp_cnt    <= HP_WIDTH'(1);
      r_hp        <= r_hp_cnt;
    end else if (r_hp_cnt == '1) begin
      r_hp        <= '1;
    end else begin
      r_hp_cnt    <= r_hp_cnt + HP_WIDTH'(1);
    end
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (avs_ctrl_address)
      4'd0: w_rd_mux = {5'b00000, r_ctrl};
      4'd1: w_rd_mux = {1'b0, r_hall_s2, 1'b0, w_running, r_hall_err, r_fault};
      4'd2: w_rd_mux = w_per16[7:0];
      4'd3: w_rd_mux = w_per16[15:8];
      4'd4: w_rd_mux = w_duty16[7:0];
      4'd5: w_rd_mux = w_duty16[15:8];
      4'd6: w_rd_mux = 8'(r_dt);
      4'd7: w_rd_mux = w_hp24[7:0];
      4'd8: w_rd_mux = r_hp_snap_hi[7:0];
      4'd9: w_rd_mux = r_hp_snap_hi[15:8];
      default: w_rd_mux = 8'h00;
    endcase
  end

  // Reading byte 0 freezes bytes 1/2 so a multi-read stays coherent
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      avs_ctrl_readdata <= 8'h00;
      r_hp_snap_hi      <= HP_ONES24[23:8];
    end else if (avs_ctrl_read) begin
      avs_ctrl_readdata <= w_rd_mux;
      if (avs_ctrl_address == 4'd7) r_hp_snap_hi <= w_hp24[23:8];
    end
  end

endmodule

// File: tb/tb_bldc_pwm_driver.sv
module tb_bldc_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] addr;
  logic       wr, rd;
  logic [7:0] wdata, rdata;
  logic       ilim, ha, hb, hc;
  logic       Lau, Lbu, Lcu, Lad, Lbd, Lcd;
  logic [5:0] g;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];

  assign g = {Lau, Lbu, Lcu, Lad, Lbd, Lcd};

  always #5 clk = ~clk;

  bldc_pwm_driver #(.PWM_WIDTH(16), .DT_WIDTH(8), .HP_WIDTH(24)) dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset_n   (rst_n),
    .avs_ctrl_address   (addr),
    .avs_ctrl_write     (wr),
    .avs_ctrl_read      (rd),
    .avs_ctrl_writedata (wdata),
    .avs_ctrl_readdata  (rdata),
    .I_limit            (ilim),
    .Ha                 (ha),
    .Hb                 (hb),
    .Hc                 (hc),
    .Lau                (Lau),
    .Lbu                (Lbu),
    .Lcu                (Lcu),
    .Lad                (Lad),
    .Lbd                (Lbd),
    .Lcd                (Lcd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic set_hall(input logic [2:0] h);
    {ha, hb, hc} = h;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    logic [7:0] ra[6];
    logic [7:0] re[6];
    rst_n = 1'b0; addr = 4'd0; wr = 1'b0; rd = 1'b0; wdata = 8'h00; ilim = 1'b0;
    set_hall(3'b100);
    repeat (3) tick();
    n_total++;
    if (g !== 6'b000000) $display("FAIL reset_gates got %b exp 000000", g); else n_pass++;
    n_total++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", rdata); else n_pass++;
    rst_n = 1'b1;
    repeat (4) tick();
    ra = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd2};
    re = '{8'h00, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(re[i]);
      bus_read(ra[i][3:0], d);
      e = sb_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL reset_reg%0d got %h exp %h", ra[i], d, e); else n_pass++;
    end
  endtask

  task automatic test_pwm();
    logic prev, found;
    logic [7:0] e;
    bus_write(4'd2, 8'd9);
    bus_write(4'd3, 8'd0);
    bus_write(4'd4, 8'd5);
    bus_write(4'd5, 8'd0);
    bus_write(4'd6, 8'd0);
    bus_write(4'd0, 8'h03);
    repeat (12) tick();
    found = 1'b0;
    prev = Lau;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!prev && Lau) found = 1'b1;
      prev = Lau;
    end
    n_total++;
    if (!found) $display("FAIL pwm_lau_rise got none exp rise within 40 cycles"); else n_pass++;
    for (int i = 0; i < 20; i++) sb_q.push_back({2'b00, ((i % 10) < 5), 5'b00001});
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      e = sb_q.pop_front();
      n_total++;
      if ({2'b00, g} !== e) $display("FAIL pwm_cycle%0d got %b exp %b", i, g, e[5:0]); else n_pass++;
    end
  endtask

  task automatic test_dead_time();
    logic [7:0] e;
    logic [5:0] m;
    int cnt_bu, cnt_au;
    bus_write(4'd6, 8'd4);
    repeat (3) tick();
    set_hall(3'b110);
    for (int k = 1; k <= 7; k++) begin
      if (k <= 2)      sb_q.push_back({2'b00, 6'b000001});
      else if (k <= 6) sb_q.push_back({2'b00, 6'b000000});
      else             sb_q.push_back({2'b00, 6'b000001});
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      m = (k <= 2) ? 6'b011111 : ((k <= 6) ? 6'b111111 : 6'b101111);
      e = sb_q.pop_front();
      n_total++;
      if ((g & m) !== e[5:0]) $display("FAIL dead_k%0d got %b exp %b (mask %b)", k, g & m, e[5:0], m);
      else n_pass++;
    end
    cnt_bu = (Lbu === 1'b1) ? 1 : 0;
    cnt_au = (Lau === 1'b1) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (Lbu === 1'b1) cnt_bu++;
      if (Lau === 1'b1) cnt_au++;
    end
    n_total++;
    if (cnt_bu != 5 || cnt_au != 0) $display("FAIL dead_chop got lbu=%0d lau=%0d exp lbu=5 lau=0", cnt_bu, cnt_au);
    else n_pass++;
  endtask

  task automatic test_duty();
    logic prev, found;
    logic [7:0] e;
    found = 1'b0;
    prev = Lbu;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!prev && Lbu) found = 1'b1;
      prev = Lbu;
    end
    n_total++;
    if (!found) $display("FAIL duty_lbu_rise got none exp rise within 40 cycles"); else n_pass++;
    for (int i = 0; i < 20; i++)
      sb_q.push_back({2'b00, 1'b0, ((i < 10) ? (i < 5) : ((i - 10) < 8)), 4'b0001});
    for (int i = 0; i < 20; i++) begin
      if (i == 3)     bus_write(4'd4, 8'd8);
      else if (i > 0) tick();
      e = sb_q.pop_front();
      n_total++;
      if ({2'b00, g} !== e) $display("FAIL duty8_cycle%0d got %b exp %b", i, g, e[5:0]); else n_pass++;
    end
    bus_write(4'd4, 8'd20);
    repeat (12) tick();
    for (int i = 0; i < 10; i++) sb_q.push_back({2'b00, 6'b010001});
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      e = sb_q.pop_front();
      n_total++;
      if ({2'b00, g} !== e) $display("FAIL duty20_cycle%0d got %b exp %b", i, g, e[5:0]); else n_pass++;
    end
  endtask

  task automatic test_fault();
    logic [7:0] d, e;
    ilim = 1'b1;
    repeat (3) tick();
    n_total++;
    if (g !== 6'b000000) $display("FAIL fault_gates_off got %b exp 000000", g); else n_pass++;
    sb_q.push_back(8'h01);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h01) !== e) $display("FAIL fault_set got %h exp %h", d & 8'h01, e); else n_pass++;
    bus_write(4'd0, 8'h0B);
    sb_q.push_back(8'h01);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h01) !== e) $display("FAIL fault_clear_blocked got %h exp %h", d & 8'h01, e); else n_pass++;
    ilim = 1'b0;
    repeat (4) tick();
    sb_q.push_back(8'h01);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h01) !== e) $display("FAIL fault_latched got %h exp %h", d & 8'h01, e); else n_pass++;
    for (int k = 0; k <= 5; k++) sb_q.push_back((k < 5) ? 8'h00 : 8'h11);
    bus_write(4'd0, 8'h0B);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      e = sb_q.pop_front();
      n_total++;
      if ({2'b00, g} !== e) $display("FAIL fault_resume_k%0d got %b exp %b", k, g, e[5:0]); else n_pass++;
    end
    sb_q.push_back(8'h00);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h01) !== e) $display("FAIL fault_cleared got %h exp %h", d & 8'h01, e); else n_pass++;
    sb_q.push_back(8'h03);
    bus_read(4'd0, d);
    e = sb_q.pop_front();
    n_total++;
    if (d !== e) $display("FAIL ctrl_readback got %h exp %h", d, e); else n_pass++;
  endtask

  task automatic test_hall_period();
    logic [7:0] d, e;
    logic [3:0] ra[5];
    logic [7:0] re[5];
    set_hall(3'b010);
    repeat (1000) tick();
    set_hall(3'b011);
    repeat (5) tick();
    ra = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd0};
    re = '{8'hE8, 8'h03, 8'h00, 8'h04, 8'h00};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(re[i]);
      bus_read(ra[i], d);
      if (ra[i] == 4'd1) d = d & 8'h04;
      e = sb_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL hp1000_addr%0d got %h exp %h", ra[i], d, e); else n_pass++;
    end
    repeat (491) tick();
    set_hall(3'b001);
    repeat (5) tick();
    ra = '{4'd8, 4'd9, 4'd7, 4'd8, 4'd9};
    re = '{8'h03, 8'h00, 8'hF4, 8'h01, 8'h00};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(re[i]);
      bus_read(ra[i], d);
      e = sb_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL hp500_read%0d_addr%0d got %h exp %h", i, ra[i], d, e); else n_pass++;
    end
  endtask

  task automatic test_hall_err_brake();
    logic [7:0] d, e;
    set_hall(3'b111);
    repeat (10) tick();
    n_total++;
    if (g !== 6'b000000) $display("FAIL hallerr_gates got %b exp 000000", g); else n_pass++;
    sb_q.push_back(8'h02);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h02) !== e) $display("FAIL hallerr_set got %h exp %h", d & 8'h02, e); else n_pass++;
    set_hall(3'b100);
    repeat (10) tick();
    n_total++;
    if (g !== 6'b100001) $display("FAIL hallerr_recover_gates got %b exp 100001", g); else n_pass++;
    sb_q.push_back(8'h02);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h02) !== e) $display("FAIL hallerr_sticky got %h exp %h", d & 8'h02, e); else n_pass++;
    bus_write(4'd0, 8'h0B);
    sb_q.push_back(8'h00);
    bus_read(4'd1, d);
    e = sb_q.pop_front();
    n_total++;
    if ((d & 8'h02) !== e) $display("FAIL hallerr_clear got %h exp %h", d & 8'h02, e); else n_pass++;
    for (int k = 0; k <= 5; k++)
      sb_q.push_back((k == 0) ? 8'h21 : ((k < 5) ? 8'h00 : 8'h07));
    bus_write(4'd0, 8'h07);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      e = sb_q.pop_front();
      n_total++;
      if ({2'b00, g} !== e) $display("FAIL brake_k%0d got %b exp %b", k, g, e[5:0]); else n_pass++;
    end
  endtask

  task automatic test_reverse_disable();
    bus_write(4'd0, 8'h01);
    repeat (10) tick();
    n_total++;
    if (g !== 6'b001100) $display("FAIL reverse_h100 got %b exp 001100", g); else n_pass++;
    bus_write(4'd0, 8'h00);
    repeat (10) tick();
    n_total++;
    if (g !== 6'b000000) $display("FAIL disable_gates got %b exp 000000", g); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, e;
    bus_write(4'd0, 8'h03);
    repeat (10) tick();
    n_total++;
    if (g !== 6'b100001) $display("FAIL premid_gates got %b exp 100001", g); else n_pass++;
    sb_q.push_back(8'h09);
    bus_read(4'd2, d);
    e = sb_q.pop_front();
    n_total++;
    if (d !== e) $display("FAIL premid_period got %h exp %h", d, e); else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (g !== 6'b000000) $display("FAIL midreset_gates got %b exp 000000", g); else n_pass++;
    n_total++;
    if (rdata !== 8'h00) $display("FAIL midreset_rdata got %h exp 00", rdata); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    sb_q.push_back(8'h00);
    bus_read(4'd2, d);
    e = sb_q.pop_front();
    n_total++;
    if (d !== e) $display("FAIL postmid_period got %h exp %h", d, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_dead_time();
    test_duty();
    test_fault();
    test_hall_period();
    test_hall_err_brake();
    test_reverse_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
